// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in, serial-out shift register with a valid/ready
// load handshake. A word accepted at one edge is transmitted one bit per
// cycle starting on the next cycle; a new word may be accepted during the
// final frame bit so that frames run back-to-back with no gap.
// Build option: define PISO_PARITY_EN to append an even-parity bit (XOR of
// the captured word) after the data bits; done and the early load_ready then
// move to that parity cycle.
module piso_shift_reg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
`ifndef PISO_PARITY_EN
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);
`endif

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;
`else
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;
`endif

  // Bit that leaves the word first, according to the shift direction.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Word with its outgoing bit removed, ready to present the next one.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif
  logic             accept;
  logic             finish;

  // Ready in IDLE and during the final frame bit (done_q marks that cycle).
  assign load_ready = rst && ((state_q == ST_IDLE) || done_q);
  assign accept     = load_valid && load_ready;

  assign dout       = dout_q;
  assign dout_valid = vld_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // Next-state logic: advance the frame, then let an accepted load override.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    vld_d    = vld_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    finish   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        dout_d = 1'b0;
        vld_d  = 1'b0;
        busy_d = 1'b0;
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
`ifdef PISO_PARITY_EN
          state_d = ST_PAR;
          cnt_d   = '0;
          dout_d  = parity_q;
          done_d  = 1'b1;
`else
          finish  = 1'b1;
`endif
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          dout_d = head_bit(sreg_q);
          sreg_d = advance(sreg_q);
`ifndef PISO_PARITY_EN
          done_d = (cnt_q == CNT_PENULT);
`endif
        end
      end
`ifdef PISO_PARITY_EN
      ST_PAR: begin
        finish = 1'b1;
      end
`endif
      default: begin
        finish = 1'b1;
      end
    endcase

    if (finish) begin
      state_d = ST_IDLE;
      sreg_d  = '0;
      cnt_d   = '0;
      dout_d  = 1'b0;
      vld_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end

    // The first bit goes straight to dout; the rest wait in the shift register.
    if (accept) begin
      state_d  = ST_SHIFT;
      sreg_d   = advance(din);
      cnt_d    = '0;
      dout_d   = head_bit(din);
      vld_d    = 1'b1;
      busy_d   = 1'b1;
      done_d   = 1'b0;
`ifdef PISO_PARITY_EN
      parity_d = ^din;
`endif
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      sreg_q   <= '0;
      cnt_q    <= '0;
      dout_q   <= 1'b0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Bench for piso_shift_reg: two instances (MSB-first and LSB-first) share the
// stimulus; a queue-based frame model is checked every cycle, and directed
// streams are pinned against hand-computed literals.
`timescale 1ns/1ps
module tb_piso_shift_reg;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int         FL       = W + 1;
  localparam logic [9:0] EXP_T1   = 10'b10111;
  localparam logic [9:0] EXP_DN1  = 10'b00001;
  localparam logic [9:0] EXP_T2   = 10'b1011101100;
  localparam logic [9:0] EXP_DN2  = 10'b0000100001;
  localparam logic [9:0] EXP_T3   = 10'b1100000110;
  localparam logic [9:0] EXP_V2   = 10'h3FF;
  localparam logic [9:0] EXP_T5_0 = 10'b00011;
  localparam logic [9:0] EXP_T5_1 = 10'b10001;
  localparam logic [9:0] EXP_T6   = 10'b10010;
  localparam logic [3:0] EXP_SIPO = 4'b0111;
`else
  localparam int         FL       = W;
  localparam logic [9:0] EXP_T1   = 10'b1011;
  localparam logic [9:0] EXP_DN1  = 10'b0001;
  localparam logic [9:0] EXP_T2   = 10'b10110110;
  localparam logic [9:0] EXP_DN2  = 10'b00010001;
  localparam logic [9:0] EXP_T3   = 10'b11000011;
  localparam logic [9:0] EXP_V2   = 10'h0FF;
  localparam logic [9:0] EXP_T5_0 = 10'b0001;
  localparam logic [9:0] EXP_T5_1 = 10'b1000;
  localparam logic [9:0] EXP_T6   = 10'b1001;
  localparam logic [3:0] EXP_SIPO = 4'b1011;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         load_valid;
  logic         r0, d0, v0, b0, dn0;
  logic         r1, d1, v1, b1, dn1;
  logic [3:0]   sipo;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  bit pend0[$];
  bit pend1[$];
  logic e_d0, e_v0, e_dn0, e_d1, e_v1, e_dn1, m_rdy, acc;

  always #5 clk = ~clk;

  piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(r0), .dout(d0), .dout_valid(v0), .busy(b0), .done(dn0)
  );

  piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(r1), .dout(d1), .dout_valid(v1), .busy(b1), .done(dn1)
  );

  // Receiver: 4-bit SIPO fed from the MSB-first instance.
  always @(posedge clk) begin
    if (!rst) sipo <= 4'b0;
    else if (v0) sipo <= {sipo[2:0], d0};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame model: each accepted word becomes a queue of bits to emit, one per cycle.
  initial begin
    forever begin
      @(posedge clk);
      acc = rst && load_valid && (pend0.size() == 0);
      if (!rst) begin
        pend0.delete();
        pend1.delete();
      end else if (acc) begin
        for (int i = 0; i < W; i++) begin
          pend0.push_back(din[W-1-i]);
          pend1.push_back(din[i]);
        end
`ifdef PISO_PARITY_EN
        pend0.push_back(^din);
        pend1.push_back(^din);
`endif
      end
      if (pend0.size() > 0) begin
        e_d0 = pend0.pop_front(); e_v0 = 1'b1; e_dn0 = (pend0.size() == 0);
      end else begin
        e_d0 = 1'b0; e_v0 = 1'b0; e_dn0 = 1'b0;
      end
      if (pend1.size() > 0) begin
        e_d1 = pend1.pop_front(); e_v1 = 1'b1; e_dn1 = (pend1.size() == 0);
      end else begin
        e_d1 = 1'b0; e_v1 = 1'b0; e_dn1 = 1'b0;
      end
      #1;
      m_rdy = rst && (pend0.size() == 0);
      chk("cyc_ready0", r0, m_rdy);
      chk("cyc_dout0", d0, e_d0);
      chk("cyc_vld0", v0, e_v0);
      chk("cyc_busy0", b0, e_v0);
      chk("cyc_done0", dn0, e_dn0);
      chk("cyc_ready1", r1, m_rdy);
      chk("cyc_dout1", d1, e_d1);
      chk("cyc_vld1", v1, e_v1);
      chk("cyc_busy1", b1, e_v1);
      chk("cyc_done1", dn1, e_dn1);
      if (dn0 === 1'b1) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Load one word from IDLE and collect its whole frame from both instances.
  task automatic run_frame(input logic [W-1:0] w, output logic [9:0] s0,
                           output logic [9:0] s1, output logic [9:0] dn);
    @(negedge clk);
    chk("rf_ready_idle", r0, 1'b1);
    din = w;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    s0 = '0; s1 = '0; dn = '0;
    for (int i = 0; i < FL; i++) begin
      s0 = {s0[8:0], d0};
      s1 = {s1[8:0], d1};
      dn = {dn[8:0], dn0};
      @(negedge clk);
    end
  endtask

  logic [9:0] s0, s1, dn, vs;
  int         dcnt_before;

  initial begin
    rst = 1'b0;
    load_valid = 1'b0;
    din = '0;
    repeat (3) @(negedge clk);
    chk("rst_dout", d0, 1'b0);
    chk("rst_vld", v0, 1'b0);
    chk("rst_busy", b0, 1'b0);
    chk("rst_done", dn0, 1'b0);
    chk("rst_ready_low", r0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_rel_ready", r0, 1'b1);

    // Single frame, SIPO receiver sees the word.
    run_frame(4'b1011, s0, s1, dn);
    chk("t1_stream", s0, EXP_T1);
    chk("t1_done", dn, EXP_DN1);
    chk("t1_sipo", sipo, EXP_SIPO);
    chk("t1_idle_vld", v0, 1'b0);
    chk("t1_idle_dout", d0, 1'b0);
    chk("t1_idle_ready", r0, 1'b1);

    // Back-to-back frames with load_valid held high.
    @(negedge clk);
    din = 4'b1011;
    load_valid = 1'b1;
    @(negedge clk);
    din = 4'b0110;
    s0 = '0; dn = '0; vs = '0;
    for (int i = 0; i < 2*FL; i++) begin
      s0 = {s0[8:0], d0};
      dn = {dn[8:0], dn0};
      vs = {vs[8:0], v0};
      if (i == 0) chk("t2_ready_busy", r0, 1'b0);
      if (i == FL-1) chk("t2_ready_last", r0, 1'b1);
      if (i == FL) load_valid = 1'b0;
      @(negedge clk);
    end
    chk("t2_stream", s0, EXP_T2);
    chk("t2_done", dn, EXP_DN2);
    chk("t2_contig", vs, EXP_V2);
    chk("t2_idle_vld", v0, 1'b0);

    // Load presented while busy is held off until the final bit.
    @(negedge clk);
    din = 4'b1100;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    s0 = '0; vs = '0;
    for (int i = 0; i < 2*FL; i++) begin
      s0 = {s0[8:0], d0};
      vs = {vs[8:0], v0};
      if (i == 1 || i == 2) chk("t3_ready_busy", r0, 1'b0);
      if (i == 1) begin
        din = 4'b0011;
        load_valid = 1'b1;
      end
      if (i == FL) load_valid = 1'b0;
      @(negedge clk);
    end
    chk("t3_stream", s0, EXP_T3);
    chk("t3_contig", vs, EXP_V2);

    // Reset in the middle of a frame.
    dcnt_before = done_cnt;
    @(negedge clk);
    din = 4'b1111;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    @(negedge clk);
    chk("t4_busy_pre", b0, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("t4_dout", d0, 1'b0);
    chk("t4_vld", v0, 1'b0);
    chk("t4_busy", b0, 1'b0);
    chk("t4_done", dn0, 1'b0);
    chk("t4_ready_in_rst", r0, 1'b0);
    rst = 1'b1;
    #1;
    chk("t4_ready_rel", r0, 1'b1);
    repeat (FL + 1) @(negedge clk);
    chk("t4_no_resume", b0, 1'b0);
    chk("t4_no_done", done_cnt, dcnt_before);

    // Bit order in both directions.
    run_frame(4'b0001, s0, s1, dn);
    chk("t5_msb_stream", s0, EXP_T5_0);
    chk("t5_lsb_stream", s1, EXP_T5_1);

    run_frame(4'b1001, s0, s1, dn);
    chk("t6_msb_stream", s0, EXP_T6);
    chk("t6_lsb_stream", s1, EXP_T6);
    chk("t6_done", dn, EXP_DN1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
